// File: rtl/gmii_tx_framer.sv
// GMII transmit frame source: preamble/SFD insertion, payload streaming,
// underrun signalling as a GMII error byte, and minimum inter-packet gap.
module gmii_tx_framer #(
    parameter int unsigned PREAMBLE_LEN = 7,
    parameter int unsigned MIN_IPG      = 12
) (
    input  logic        GTX_CLK,
    input  logic        mr_main_reset,
    input  logic        xmit,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    input  logic        s_last,
    input  logic        s_error,
    output logic        s_ready,
    output logic [7:0]  TXD,
    output logic        TX_EN,
    output logic        TX_ER,
    output logic        busy,
    output logic        frame_done,
    output logic        underrun,
    output logic [15:0] frames_sent
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_ERR,
        ST_IPG
    } state_t;

    localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);
    localparam logic [7:0] IPG_LAST = 8'(MIN_IPG - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        last_q, last_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        frame_done_q, frame_done_d;
    logic        underrun_q, underrun_d;
    logic [15:0] frames_sent_q, frames_sent_d;
    logic        start;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        frames_sent_d = frames_sent_q;
        frame_done_d  = 1'b0;
        underrun_d    = 1'b0;
        txd_d         = '0;
        tx_en_d       = 1'b0;
        tx_er_d       = 1'b0;
        start         = xmit && s_valid;
        s_ready       = (state_q == ST_SFD) || ((state_q == ST_DATA) && !last_q);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_PRE;
                    cnt_d   = '0;
                end
            end
            ST_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = ST_SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_SFD, ST_DATA: begin
                if (s_ready) begin
                    if (s_valid) begin
                        state_d = ST_DATA;
                        last_d  = s_last;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    // Final byte is on the wire this cycle; the gap starts next.
                    state_d       = ST_IPG;
                    cnt_d         = '0;
                    last_d        = 1'b0;
                    frame_done_d  = 1'b1;
                    frames_sent_d = frames_sent_q + 16'd1;
                end
            end
            ST_ERR: begin
                state_d = ST_IPG;
                cnt_d   = '0;
                last_d  = 1'b0;
            end
            ST_IPG: begin
                if (cnt_q == IPG_LAST) begin
                    state_d = start ? ST_PRE : ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                last_d  = 1'b0;
            end
        endcase

        // Wire content is registered from the state being entered.
        case (state_d)
            ST_PRE: begin
                txd_d   = 8'h55;
                tx_en_d = 1'b1;
            end
            ST_SFD: begin
                txd_d   = 8'hD5;
                tx_en_d = 1'b1;
            end
            ST_DATA: begin
                txd_d   = s_data;
                tx_en_d = 1'b1;
                tx_er_d = s_error;
            end
            ST_ERR: begin
                txd_d      = 8'hFF;
                tx_en_d    = 1'b1;
                tx_er_d    = 1'b1;
                underrun_d = 1'b1;
            end
            default: begin
                txd_d   = '0;
                tx_en_d = 1'b0;
                tx_er_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            last_q        <= 1'b0;
            txd_q         <= '0;
            tx_en_q       <= 1'b0;
            tx_er_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            underrun_q    <= 1'b0;
            frames_sent_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            txd_q         <= txd_d;
            tx_en_q       <= tx_en_d;
            tx_er_q       <= tx_er_d;
            frame_done_q  <= frame_done_d;
            underrun_q    <= underrun_d;
            frames_sent_q <= frames_sent_d;
        end
    end

    assign TXD         = txd_q;
    assign TX_EN       = tx_en_q;
    assign TX_ER       = tx_er_q;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = frame_done_q;
    assign underrun    = underrun_q;
    assign frames_sent = frames_sent_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Bench for gmii_tx_framer: wire activity is logged and scored against
// frame-level expectations built from the payload, error and underrun choices.
module tb_gmii_tx_framer;

    localparam int PRE_LEN = 7;
    localparam int IPG     = 12;

    logic        GTX_CLK;
    logic        mr_main_reset;
    logic        xmit;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        s_last;
    logic        s_error;
    logic        s_ready;
    logic [7:0]  TXD;
    logic        TX_EN;
    logic        TX_ER;
    logic        busy;
    logic        frame_done;
    logic        underrun;
    logic [15:0] frames_sent;

    gmii_tx_framer #(
        .PREAMBLE_LEN(PRE_LEN),
        .MIN_IPG     (IPG)
    ) dut (
        .GTX_CLK      (GTX_CLK),
        .mr_main_reset(mr_main_reset),
        .xmit         (xmit),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_error      (s_error),
        .s_ready      (s_ready),
        .TXD          (TXD),
        .TX_EN        (TX_EN),
        .TX_ER        (TX_ER),
        .busy         (busy),
        .frame_done   (frame_done),
        .underrun     (underrun),
        .frames_sent  (frames_sent)
    );

    initial GTX_CLK = 1'b0;
    always #5 GTX_CLK = ~GTX_CLK;

    typedef struct packed {
        logic       en;
        logic       er;
        logic [7:0] txd;
        logic       fd;
        logic       ur;
    } obs_t;

    int          vectors    = 0;
    int          miscompares = 0;
    obs_t        log_q[$];
    bit          logging = 1'b0;
    logic [9:0]  exp_stream[$];
    bit          exp_ur[$];
    logic [15:0] exp_sent = '0;
    int          first_burst_at;
    logic [7:0]  pay[16];

    // Outputs are sampled 2 ns after each rising edge.
    always @(posedge GTX_CLK) begin
        #2;
        if (logging) log_q.push_back({TX_EN, TX_ER, TXD, frame_done, underrun});
    end

    // Expected wire burst for one frame: preamble, SFD, sent bytes, optional error byte.
    task automatic model_frame(input int n, input int upos, input int errpos);
        int k;
        for (int p = 0; p < PRE_LEN; p++) exp_stream.push_back({1'b1, 1'b0, 8'h55});
        exp_stream.push_back({1'b1, 1'b0, 8'hD5});
        k = (upos >= 0) ? upos : n;
        for (int i = 0; i < k; i++) exp_stream.push_back({1'b1, (i == errpos), pay[i]});
        if (upos >= 0) begin
            exp_stream.push_back({1'b1, 1'b1, 8'hFF});
            exp_ur.push_back(1'b1);
        end else begin
            exp_ur.push_back(1'b0);
            exp_sent = exp_sent + 16'd1;
        end
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic drive_frame(input int n, input int upos, input int errpos, input int xoff);
        int i   = 0;
        int cyc = 0;
        while (i < n) begin
            if (cyc == 300) begin
                vectors++;
                miscompares++;
                $display("FAIL drive_timeout: accepted %0d of %0d bytes, required all", i, n);
                return;
            end
            if (i == xoff) xmit = 1'b0;
            s_data  = pay[i];
            s_last  = (i == n - 1);
            s_error = (i == errpos);
            if (s_ready && i == upos) begin
                s_valid = 1'b0;
                @(negedge GTX_CLK);
                return;
            end
            s_valid = 1'b1;
            if (s_ready) i++;
            @(negedge GTX_CLK);
            cyc++;
        end
    endtask

    task automatic score_log(input bit exact_gap);
        int e = 0, f = 0, gap = 0, nfd = 0, nur = 0, xfd = 0, xur = 0;
        bit in_b = 1'b0, seen = 1'b0;
        first_burst_at = -1;
        foreach (exp_ur[k]) if (exp_ur[k]) xur++; else xfd++;
        for (int j = 0; j < log_q.size(); j++) begin
            obs_t w = log_q[j];
            if (w.fd) nfd++;
            if (w.ur) nur++;
            if (w.en) begin
                if (!in_b) begin
                    if (first_burst_at < 0) first_burst_at = j;
                    if (seen) begin
                        vectors++;
                        if (exact_gap ? (gap != IPG) : (gap < IPG)) begin
                            miscompares++;
                            $display("FAIL ipg_gap: got %0d idle cycles, required %s%0d", gap, exact_gap ? "" : ">=", IPG);
                        end
                    end
                    in_b = 1'b1;
                end
                vectors++;
                if (e >= exp_stream.size()) begin
                    miscompares++;
                    $display("FAIL wire_extra: got {en,er,txd}=%h at log %0d, required no byte", {w.en, w.er, w.txd}, j);
                end else if ({w.en, w.er, w.txd} !== exp_stream[e]) begin
                    miscompares++;
                    $display("FAIL wire_byte: got {en,er,txd}=%h at log %0d, required %h", {w.en, w.er, w.txd}, j, exp_stream[e]);
                end
                e++;
            end else begin
                if (in_b) begin
                    in_b = 1'b0;
                    seen = 1'b1;
                    gap  = 0;
                    if (f < exp_ur.size()) begin
                        vectors++;
                        if (log_q[j-1].ur !== exp_ur[f]) begin
                            miscompares++;
                            $display("FAIL underrun_pulse: got %b on last wire byte of frame %0d, required %b", log_q[j-1].ur, f, exp_ur[f]);
                        end
                        vectors++;
                        if (w.fd !== !exp_ur[f]) begin
                            miscompares++;
                            $display("FAIL frame_done_pulse: got %b on first gap cycle of frame %0d, required %b", w.fd, f, !exp_ur[f]);
                        end
                    end
                    f++;
                end
                gap++;
                vectors++;
                if (w.txd !== 8'h00 || w.er !== 1'b0) begin
                    miscompares++;
                    $display("FAIL idle_wire: got txd=%h er=%b at log %0d, required 00 0", w.txd, w.er, j);
                end
            end
        end
        vectors++;
        if (e != exp_stream.size()) begin
            miscompares++;
            $display("FAIL wire_length: got %0d enabled bytes, required %0d", e, exp_stream.size());
        end
        vectors++;
        if (f != exp_ur.size()) begin
            miscompares++;
            $display("FAIL burst_count: got %0d, required %0d", f, exp_ur.size());
        end
        vectors++;
        if (nfd != xfd || nur != xur) begin
            miscompares++;
            $display("FAIL pulse_count: got done=%0d underrun=%0d, required %0d %0d", nfd, nur, xfd, xur);
        end
        vectors++;
        if (frames_sent !== exp_sent) begin
            miscompares++;
            $display("FAIL frames_sent: got %h, required %h", frames_sent, exp_sent);
        end
        log_q.delete();
        exp_stream.delete();
        exp_ur.delete();
    endtask

    task automatic idle_and_score(input bit exact_gap);
        s_valid = 1'b0;
        repeat (IPG + 4) @(negedge GTX_CLK);
        logging = 1'b0;
        score_log(exact_gap);
    endtask

    task automatic test_reset;
        mr_main_reset = 1'b1;
        xmit = 1'b1; s_valid = 1'b1; s_data = 8'h01; s_last = 1'b0; s_error = 1'b0;
        repeat (3) @(negedge GTX_CLK);
        vectors++;
        if ({TXD, TX_EN, TX_ER, s_ready, busy, frame_done, underrun, frames_sent} !== 30'd0) begin
            miscompares++;
            $display("FAIL reset_state: got txd=%h en=%b er=%b rdy=%b busy=%b fd=%b ur=%b cnt=%h, required all zero",
                     TXD, TX_EN, TX_ER, s_ready, busy, frame_done, underrun, frames_sent);
        end
    endtask

    task automatic test_first_frame;
        for (int i = 0; i < 4; i++) pay[i] = 8'(i + 1);
        model_frame(4, -1, -1);
        mr_main_reset = 1'b0;
        logging = 1'b1;
        drive_frame(4, -1, -1, -1);
        idle_and_score(1'b0);
        vectors++;
        if (first_burst_at != 0) begin
            miscompares++;
            $display("FAIL start_latency: got first preamble at log %0d, required 0", first_burst_at);
        end
    endtask

    task automatic test_back_to_back;
        logging = 1'b1;
        for (int fr = 0; fr < 2; fr++) begin
            for (int i = 0; i < 4; i++) pay[i] = 8'($urandom);
            model_frame(4, -1, -1);
            drive_frame(4, -1, -1, -1);
        end
        idle_and_score(1'b1);
    endtask

    task automatic test_underrun;
        for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
        model_frame(5, 2, -1);
        logging = 1'b1;
        drive_frame(5, 2, -1, -1);
        idle_and_score(1'b0);
    endtask

    task automatic test_error_byte;
        for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
        model_frame(5, -1, 2);
        logging = 1'b1;
        drive_frame(5, -1, 2, -1);
        idle_and_score(1'b0);
    endtask

    task automatic test_xmit;
        xmit = 1'b0; s_valid = 1'b1; s_data = 8'h3C; s_last = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge GTX_CLK);
            vectors++;
            if (TX_EN !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL xmit_hold: got en=%b rdy=%b busy=%b, required 0 0 0", TX_EN, s_ready, busy);
            end
        end
        for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
        model_frame(6, -1, -1);
        xmit = 1'b1;
        logging = 1'b1;
        drive_frame(6, -1, -1, 2);
        idle_and_score(1'b0);
        vectors++;
        if (first_burst_at != 0) begin
            miscompares++;
            $display("FAIL xmit_start: got first preamble at log %0d, required 0", first_burst_at);
        end
        xmit = 1'b1;
    endtask

    task automatic test_random;
        int n, upos, errpos, idle;
        logging = 1'b1;
        for (int fr = 0; fr < 10; fr++) begin
            n      = int'($urandom_range(1, 8));
            upos   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            errpos = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            for (int i = 0; i < n; i++) pay[i] = 8'($urandom);
            model_frame(n, upos, errpos);
            drive_frame(n, upos, errpos, -1);
            idle = int'($urandom_range(0, 15));
            if (idle > 0) begin
                s_valid = 1'b0;
                repeat (idle) @(negedge GTX_CLK);
            end
        end
        idle_and_score(1'b0);
    endtask

    task automatic test_async_reset;
        int k = 0;
        xmit = 1'b1; s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b0; s_error = 1'b0;
        while (!s_ready && k < 40) begin
            @(negedge GTX_CLK);
            k++;
        end
        @(negedge GTX_CLK);
        vectors++;
        if (TX_EN !== 1'b1 || TXD !== 8'hA5 || frames_sent !== exp_sent) begin
            miscompares++;
            $display("FAIL pre_reset_data: got en=%b txd=%h cnt=%h, required 1 a5 %h", TX_EN, TXD, frames_sent, exp_sent);
        end
        @(posedge GTX_CLK);
        #2;
        mr_main_reset = 1'b1;
        #1;
        vectors++;
        if (TX_EN !== 1'b0 || TXD !== 8'h00 || TX_ER !== 1'b0 || frames_sent !== 16'h0000 || busy !== 1'b0 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got en=%b txd=%h er=%b cnt=%h busy=%b rdy=%b, required 0 00 0 0000 0 0",
                     TX_EN, TXD, TX_ER, frames_sent, busy, s_ready);
        end
        @(negedge GTX_CLK);
        s_valid = 1'b0;
        @(negedge GTX_CLK);
        mr_main_reset = 1'b0;
        exp_sent = '0;
        repeat (2) @(negedge GTX_CLK);
    endtask

    task automatic test_count_wrap;
        force dut.frames_sent_q = 16'hFFFF;
        @(negedge GTX_CLK);
        release dut.frames_sent_q;
        @(negedge GTX_CLK);
        vectors++;
        if (frames_sent !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL preset_count: got %h, required ffff", frames_sent);
        end
        exp_sent = 16'hFFFF;
        for (int i = 0; i < 3; i++) pay[i] = 8'($urandom);
        model_frame(3, -1, -1);
        logging = 1'b1;
        drive_frame(3, -1, -1, -1);
        idle_and_score(1'b0);
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_underrun();
        test_error_byte();
        test_xmit();
        test_random();
        test_async_reset();
        test_count_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gmii_tx_framer.md
Name: gmii_tx_framer

Overview:
GMII-side frame source that sits directly upstream of the PCS transmit ordered-set and encode stages. It drives TXD/TX_EN/TX_ER into them.
Accepts payload bytes over a valid/ready stream, prepends preamble and SFD, enforces a minimum inter-packet gap, and signals underrun as a GMII error.
Gives the PCS transmit path a protocol-correct, self-timed GMII source for directed and loopback testing.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 preamble bytes before SFD (legal 1..7)
MIN_IPG, 12, minimum TX_EN-low cycles between frames (legal 1..255)

Ports:
GTX_CLK  input  1  transmit clock; all logic on rising edge
mr_main_reset  input  1  asynchronous, active-high reset
xmit  input  1  1 = framer allowed to start frames; 0 = hold idle
s_valid  input  1  payload byte available
s_data  input  8  payload byte
s_last  input  1  qualifies s_data as final byte of frame
s_error  input  1  byte to be sent with TX_ER=1
s_ready  output  1  framer accepts s_data this cycle
TXD  output  8  GMII transmit data, registered
TX_EN  output  1  GMII transmit enable, registered
TX_ER  output  1  GMII transmit error, registered
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse on the first IPG cycle after a completed frame
underrun  output  1  one-cycle pulse on the ERR cycle
frames_sent  output  16  count of completed frames (s_last accepted); wraps 0xFFFF->0x0000

Behaviour:
- One clock: GTX_CLK. Reset is asynchronous and active-high: mr_main_reset.
- Reset (asynchronous, any state): state=IDLE, TXD=0x00, TX_EN=0, TX_ER=0, s_ready=0, busy=0, frame_done=0, underrun=0, frames_sent=0, all counters 0. A frame in flight is dropped without a trailing error byte.
- State names the content currently on the wire: IDLE, PRE, SFD, DATA, ERR, IPG.
- IDLE: TX_EN=0, TXD=0x00, TX_ER=0.
  - Start condition: xmit && s_valid. When met -> PRE next cycle.
  - Start does not consume the byte.
- PRE: TXD=0x55, TX_EN=1 for exactly PREAMBLE_LEN cycles, then SFD.
- SFD: TXD=0xD5, TX_EN=1, one cycle.
- s_ready = (state==SFD) || (state==DATA && last byte not yet accepted). It is combinational from state.
- A byte accepted in cycle N (s_valid && s_ready) appears on TXD in cycle N+1, with TX_EN=1 and TX_ER=s_error. State is DATA.
- If s_last is accepted in cycle N: byte appears at N+1, IPG at N+2, frame_done=1 at N+2, and frames_sent increments at N+2.
- Underrun: s_ready=1 and s_valid=0 in SFD or DATA -> next cycle ERR.
  - ERR: TX_EN=1, TX_ER=1, TXD=0xFF, underrun=1 for one cycle, then IPG.
  - frames_sent is not incremented and frame_done does not pulse.
- IPG: TX_EN=0, TX_ER=0, TXD=0x00. Counts cycles 0..MIN_IPG-1.
  - In cycle MIN_IPG-1: start condition true -> PRE; otherwise -> IDLE.
  - Result: TX_EN low for exactly MIN_IPG cycles on back-to-back frames.
- xmit deasserted mid-frame does not abort; the frame completes normally. xmit is only sampled at start.
- Zero-length frames are impossible: the first data byte defines the frame. A single-byte frame is s_last on the first accepted byte.
- s_data, s_last and s_error are ignored when s_ready=0.
- Latency: start-condition cycle -> first data byte on TXD = PREAMBLE_LEN+2 cycles (9 with defaults).

Test Plan:
1. Reset with s_valid=1, xmit=1, then release. Cycle after release -> start seen. Next 7 cycles TXD=0x55, then 0xD5, then payload 0x01..0x04 with TX_EN=1 and TX_ER=0. Then TX_EN=0, frame_done pulse, frames_sent=1.
2. Two 4-byte frames back-to-back with s_valid held high -> exactly 12 TX_EN=0 cycles between the last byte of frame 1 and the first 0x55 of frame 2. frames_sent=2.
3. Drop s_valid for one cycle after byte 2 of a 5-byte frame -> next cycle TXD=0xFF, TX_EN=1, TX_ER=1, underrun=1. Then IPG. frames_sent unchanged.
4. s_error=1 on byte 3 -> that byte on TXD with TX_ER=1. Frame completes normally and frames_sent increments.
5. xmit=0 with s_valid=1 -> TX_EN stays 0 and s_ready stays 0. Raise xmit -> frame starts the next cycle. Lower xmit mid-frame -> frame completes.
6. Assert mr_main_reset asynchronously (mid-clock) during DATA -> TX_EN=0, TXD=0x00, frames_sent=0 immediately, without waiting for a clock edge. Preset frames_sent=0xFFFF with one more completed frame -> 0x0000.
